// File: rtl/wuxing_rel_decoder.sv
// WuXing relation decoder: checks relation vectors against element state, scores elements per window,
// and hands out one diagnosis report per window. Define WUXING_PERIOD_EN to enable recurrence-period tracking.
module wuxing_rel_decoder #(
  parameter int WINDOW  = 8,
  parameter int SCORE_W = 6,
  parameter int CNT_W   = 8,
  parameter int STUCK_N = 4
) (
  input  logic                      clk_6Hz,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [4:0]                state_in,
  input  logic [9:0]                rel_act_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [2:0]                dom_idx,
  output logic signed [SCORE_W-1:0] dom_score,
  output logic [2:0]                def_idx,
  output logic signed [SCORE_W-1:0] def_score,
  output logic [CNT_W-1:0]          mism_cnt,
  output logic                      stuck,
  output logic [3:0]                period,
  output logic                      ovf
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int RUN_W = $clog2(STUCK_N + 1);
  localparam logic signed [SCORE_W-1:0] S_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic {ACC, HOLD} fsm_t;

  fsm_t                      r_fsm;
  logic [WIN_W-1:0]          r_win_cnt;
  logic [RUN_W-1:0]          r_run;
  logic [4:0]                r_prev_state;
  logic signed [SCORE_W-1:0] r_score [5];
  logic [CNT_W-1:0]          r_mism;
  logic                      r_stuck;

  logic                      w_first;
  logic                      w_last;
  logic                      w_load;
  logic [9:0]                w_exp_rel;
  logic [4:0]                w_inc;
  logic [4:0]                w_dec;
  logic signed [SCORE_W-1:0] w_score_nx [5];
  logic [RUN_W-1:0]          w_run_nx;
  logic [CNT_W-1:0]          w_mism_nx;
  logic                      w_stuck_nx;
  logic [3:0]                w_per_nx;
  logic [2:0]                w_dom_idx;
  logic [2:0]                w_def_idx;
  logic signed [SCORE_W-1:0] w_dom_score;
  logic signed [SCORE_W-1:0] w_def_score;

  assign w_first = (r_win_cnt == '0);
  assign w_last  = (r_win_cnt == WIN_W'(WINDOW - 1));
  assign w_load  = in_valid && w_last && ((r_fsm == ACC) || out_ready);

  assign w_exp_rel = {
    state_in[4] &  state_in[2],
    state_in[2] &  state_in[3],
    state_in[3] &  state_in[1],
    state_in[1] &  state_in[0],
    state_in[0] &  state_in[4],
    state_in[4] & ~state_in[3],
    state_in[3] & ~state_in[0],
    state_in[0] & ~state_in[2],
    state_in[2] & ~state_in[1],
    state_in[1] & ~state_in[4]
  };

  // Element order {Jin, Mu, Shui, Huo, Tu}: Sheng bits raise the target, Ke bits lower it.
  assign w_inc = {rel_act_in[5], rel_act_in[8], rel_act_in[9], rel_act_in[7], rel_act_in[6]};
  assign w_dec = {rel_act_in[0], rel_act_in[4], rel_act_in[2], rel_act_in[1], rel_act_in[3]};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_score
      assign w_score_nx[gi] =
        (w_inc[gi] && !w_dec[gi] && (r_score[gi] != S_MAX)) ? r_score[gi] + SCORE_W'(1) :
        (w_dec[gi] && !w_inc[gi] && (r_score[gi] != S_MIN)) ? r_score[gi] - SCORE_W'(1) :
        r_score[gi];
    end
  endgenerate

  assign w_run_nx = (w_first || (state_in != r_prev_state)) ? RUN_W'(1) :
                    (r_run == RUN_W'(STUCK_N))              ? r_run :
                    r_run + RUN_W'(1);
  assign w_stuck_nx = r_stuck || (w_run_nx == RUN_W'(STUCK_N));
  assign w_mism_nx  = ((w_exp_rel != rel_act_in) && (r_mism != {CNT_W{1'b1}})) ?
                      r_mism + CNT_W'(1) : r_mism;

  // Strict comparisons keep the lowest index on ties.
  always_comb begin
    w_dom_idx   = 3'd0;
    w_dom_score = w_score_nx[0];
    w_def_idx   = 3'd0;
    w_def_score = w_score_nx[0];
    for (int i = 1; i < 5; i++) begin
      if (w_score_nx[i] > w_dom_score) begin
        w_dom_idx   = 3'(i);
        w_dom_score = w_score_nx[i];
      end
      if (w_score_nx[i] < w_def_score) begin
        w_def_idx   = 3'(i);
        w_def_score = w_score_nx[i];
      end
    end
  end

`ifdef WUXING_PERIOD_EN
  logic [4:0] r_ref;
  logic [3:0] r_per;

  // r_per == 0 doubles as "not found yet" since a found period is always >= 1.
  always_comb begin
    w_per_nx = r_per;
    if (!w_first && (r_per == 4'd0) && (state_in == r_ref))
      w_per_nx = (32'(r_win_cnt) > 15) ? 4'd15 : 4'(r_win_cnt);
  end
`else
  assign w_per_nx = 4'd0;
  assign period   = 4'd0;
`endif

  always_ff @(posedge clk_6Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm        <= ACC;
      r_win_cnt    <= '0;
      r_run        <= '0;
      r_prev_state <= '0;
      r_mism       <= '0;
      r_stuck      <= 1'b0;
      for (int i = 0; i < 5; i++) r_score[i] <= '0;
      out_valid    <= 1'b0;
      dom_idx      <= '0;
      dom_score    <= '0;
      def_idx      <= '0;
      def_score    <= '0;
      mism_cnt     <= '0;
      stuck        <= 1'b0;
      ovf          <= 1'b0;
`ifdef WUXING_PERIOD_EN
      r_ref        <= '0;
      r_per        <= '0;
      period       <= '0;
`endif
    end else begin
      if (in_valid) begin
        r_prev_state <= state_in;
        r_run        <= w_run_nx;
        if (w_last) begin
          r_win_cnt <= '0;
          r_mism    <= '0;
          r_stuck   <= 1'b0;
          for (int i = 0; i < 5; i++) r_score[i] <= '0;
`ifdef WUXING_PERIOD_EN
          r_per     <= '0;
`endif
        end else begin
          r_win_cnt <= r_win_cnt + WIN_W'(1);
          r_mism    <= w_mism_nx;
          r_stuck   <= w_stuck_nx;
          for (int i = 0; i < 5; i++) r_score[i] <= w_score_nx[i];
`ifdef WUXING_PERIOD_EN
          if (w_first) r_ref <= state_in;
          r_per     <= w_per_nx;
`endif
        end
      end

      if (w_load) begin
        dom_idx   <= w_dom_idx;
        dom_score <= w_dom_score;
        def_idx   <= w_def_idx;
        def_score <= w_def_score;
        mism_cnt  <= w_mism_nx;
        stuck     <= w_stuck_nx;
`ifdef WUXING_PERIOD_EN
        period    <= w_per_nx;
`endif
      end

      case (r_fsm)
        ACC: begin
          if (w_load) begin
            r_fsm     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          // A window closing while the held report is still unclaimed is dropped.
          if (in_valid && w_last) begin
            if (!out_ready) ovf <= 1'b1;
          end else if (out_ready) begin
            r_fsm     <= ACC;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_fsm     <= ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wuxing_rel_decoder.sv
// Directed bench for wuxing_rel_decoder: default instance plus a SCORE_W=4/WINDOW=12 instance for saturation.
module tb_wuxing_rel_decoder;

  logic clk_6Hz = 1'b0;
  always #5 clk_6Hz = ~clk_6Hz;

  logic              rst_n;
  logic              in_valid;
  logic [4:0]        state_in;
  logic [9:0]        rel_act_in;
  logic              out_ready;
  logic              out_valid;
  logic [2:0]        dom_idx;
  logic signed [5:0] dom_score;
  logic [2:0]        def_idx;
  logic signed [5:0] def_score;
  logic [7:0]        mism_cnt;
  logic              stuck;
  logic [3:0]        period;
  logic              ovf;

  logic              s_ready;
  logic              s_out_valid;
  logic [2:0]        s_dom_idx;
  logic signed [3:0] s_dom_score;
  logic [2:0]        s_def_idx;
  logic signed [3:0] s_def_score;
  logic [7:0]        s_mism_cnt;
  logic              s_stuck;
  logic [3:0]        s_period;
  logic              s_ovf;

`ifdef WUXING_PERIOD_EN
  localparam int P_ON = 1;
`else
  localparam int P_ON = 0;
`endif

  localparam logic [4:0] ST_TU  = 5'b00001;
  localparam logic [9:0] REL_TU = 10'b0000000100;
  localparam logic [4:0] ST_MS  = 5'b01100;
  localparam logic [9:0] REL_MS = 10'b0100001010;

  wuxing_rel_decoder u_dut (
    .clk_6Hz(clk_6Hz), .rst_n(rst_n), .in_valid(in_valid), .state_in(state_in),
    .rel_act_in(rel_act_in), .out_ready(out_ready), .out_valid(out_valid),
    .dom_idx(dom_idx), .dom_score(dom_score), .def_idx(def_idx), .def_score(def_score),
    .mism_cnt(mism_cnt), .stuck(stuck), .period(period), .ovf(ovf)
  );

  wuxing_rel_decoder #(.WINDOW(12), .SCORE_W(4), .CNT_W(8), .STUCK_N(4)) u_sat (
    .clk_6Hz(clk_6Hz), .rst_n(rst_n), .in_valid(in_valid), .state_in(state_in),
    .rel_act_in(rel_act_in), .out_ready(s_ready), .out_valid(s_out_valid),
    .dom_idx(s_dom_idx), .dom_score(s_dom_score), .def_idx(s_def_idx), .def_score(s_def_score),
    .mism_cnt(s_mism_cnt), .stuck(s_stuck), .period(s_period), .ovf(s_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [9:0] r);
    @(negedge clk_6Hz);
    in_valid   = v;
    state_in   = s;
    rel_act_in = r;
  endtask

  // Gap cycle with garbage data that must be ignored.
  task automatic idle();
    drive(1'b0, 5'h1F, 10'h3FF);
  endtask

  // Eight samples alternating a/b; the first nbad carry rel=0. Checks out_valid just before the last one.
  task automatic send_win(input string tag, input logic [4:0] sa, input logic [9:0] ra,
                          input logic [4:0] sb, input logic [9:0] rb, input int nbad,
                          input int pre_valid);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 2 == 0) ? sa : sb,
            (i < nbad) ? 10'd0 : ((i % 2 == 0) ? ra : rb));
      if (i == 7) chk({tag, ".pre_valid"}, int'(out_valid), pre_valid);
    end
  endtask

  task automatic chk_report(input string tag, input int di, input int ds, input int fi,
                            input int fs, input int mc, input int st, input int pe);
    chk({tag, ".out_valid"}, int'(out_valid), 1);
    chk({tag, ".dom_idx"},   int'(dom_idx),   di);
    chk({tag, ".dom_score"}, int'(dom_score), ds);
    chk({tag, ".def_idx"},   int'(def_idx),   fi);
    chk({tag, ".def_score"}, int'(def_score), fs);
    chk({tag, ".mism_cnt"},  int'(mism_cnt),  mc);
    chk({tag, ".stuck"},     int'(stuck),     st);
    chk({tag, ".period"},    int'(period),    pe);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    state_in   = '0;
    rel_act_in = '0;
    out_ready  = 1'b1;
    s_ready    = 1'b1;

    // T1 reset state
    repeat (2) @(negedge clk_6Hz);
    chk("t1.out_valid", int'(out_valid), 0);
    chk("t1.ovf",       int'(ovf),       0);
    chk("t1.dom_idx",   int'(dom_idx),   0);
    chk("t1.dom_score", int'(dom_score), 0);
    chk("t1.def_idx",   int'(def_idx),   0);
    chk("t1.def_score", int'(def_score), 0);
    chk("t1.mism_cnt",  int'(mism_cnt),  0);
    chk("t1.stuck",     int'(stuck),     0);
    chk("t1.period",    int'(period),    0);
    chk("t1.s_out_valid", int'(s_out_valid), 0);
    rst_n = 1'b1;

    // T2 constant Tu state, Shui takes eight Ke hits
    send_win("t2", ST_TU, REL_TU, ST_TU, REL_TU, 0, 0);
    idle();
    chk_report("t2", 0, 0, 2, -8, 0, 1, P_ON);
    idle();
    chk("t2.post_valid", int'(out_valid), 0);

    // T2b Mu/Shui state: Mu +8, Tu and Huo -8 (tie resolves to Tu)
    send_win("t2b", ST_MS, REL_MS, ST_MS, REL_MS, 0, 0);
    idle();
    chk_report("t2b", 3, 8, 0, -8, 0, 1, P_ON);
    idle();

    // T2c alternating states: never stuck, period 2
    send_win("t2c", ST_TU, REL_TU, ST_MS, REL_MS, 0, 0);
    idle();
    chk_report("t2c", 3, 4, 0, -4, 0, 0, 2 * P_ON);
    idle();

    // T3 three samples with rel=0
    send_win("t3", ST_TU, REL_TU, ST_TU, REL_TU, 3, 0);
    idle();
    chk_report("t3", 0, 0, 2, -5, 3, 1, P_ON);
    idle();

    // T4 downstream stalls over two windows
    out_ready = 1'b0;
    send_win("t4a", ST_TU, REL_TU, ST_TU, REL_TU, 0, 0);
    idle();
    chk("t4a.out_valid", int'(out_valid), 1);
    chk("t4a.ovf",       int'(ovf),       0);
    send_win("t4b", ST_TU, REL_TU, ST_TU, REL_TU, 3, 1);
    idle();
    chk_report("t4b", 0, 0, 2, -8, 0, 1, P_ON);
    chk("t4b.ovf", int'(ovf), 1);
    out_ready = 1'b1;
    idle();
    chk("t4c.out_valid", int'(out_valid), 0);
    chk("t4c.ovf",       int'(ovf),       1);

    // T5 in_valid toggling with garbage in the gaps
    for (int c = 0; c < 15; c++) begin
      if (c % 2 == 0) drive(1'b1, ST_TU, REL_TU);
      else            idle();
      if (c == 14) chk("t5.pre_valid", int'(out_valid), 0);
    end
    idle();
    chk_report("t5", 0, 0, 2, -8, 0, 1, P_ON);
    idle();
    chk("t5.post_valid", int'(out_valid), 0);

    // T6 reset discards a held report and a partial window
    out_ready = 1'b0;
    send_win("t6a", ST_TU, REL_TU, ST_TU, REL_TU, 1, 0);
    idle();
    chk("t6a.out_valid", int'(out_valid), 1);
    chk("t6a.mism_cnt",  int'(mism_cnt),  1);
    for (int i = 0; i < 5; i++) drive(1'b1, 5'b00010, 10'd0);
    @(negedge clk_6Hz);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t6r.out_valid", int'(out_valid), 0);
    chk("t6r.ovf",       int'(ovf),       0);
    chk("t6r.mism_cnt",  int'(mism_cnt),  0);
    @(negedge clk_6Hz);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_win("t6", ST_TU, REL_TU, ST_TU, REL_TU, 0, 0);
    idle();
    chk_report("t6", 0, 0, 2, -8, 0, 1, P_ON);
    chk("t6.ovf", int'(ovf), 0);

    // T6s four more samples complete the 12-sample window of the narrow-score instance
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ST_TU, REL_TU);
      if (i == 3) chk("t6s.pre_valid", int'(s_out_valid), 0);
    end
    idle();
    chk("t6s.out_valid", int'(s_out_valid), 1);
    chk("t6s.dom_idx",   int'(s_dom_idx),   0);
    chk("t6s.dom_score", int'(s_dom_score), 0);
    chk("t6s.def_idx",   int'(s_def_idx),   2);
    chk("t6s.def_score", int'(s_def_score), -8);
    chk("t6s.mism_cnt",  int'(s_mism_cnt),  0);
    chk("t6s.stuck",     int'(s_stuck),     1);
    chk("t6s.period",    int'(s_period),    P_ON);
    chk("t6s.ovf",       int'(s_ovf),       0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
